miriscv_mem_arbiter: RTL and testbench
======================================

MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: STARVE_LIMIT, default 4, the maximum number of consecutive data grants issued while an instruction request waits (legal range 1..15).
REQ-002 The block SHALL use XLEN = 32 from miriscv_pkg for all address and data widths.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock, rising edge; arstn_i  in  1  asynchronous reset, active low.
REQ-004 The instruction requester port SHALL be: instr_req_i  in  1  fetch request; instr_addr_i  in  XLEN  fetch address; instr_gnt_o  out  1  request accepted; instr_rvalid_o  out  1  fetch data valid; instr_rdata_o  out  XLEN  fetch data.
REQ-005 The data requester port SHALL be: data_req_i  in  1  load/store request; data_we_i  in  1  write enable; data_be_i  in  4  byte enables; data_addr_i  in  XLEN  address; data_wdata_i  in  XLEN  write data; data_gnt_o  out  1  accepted; data_rvalid_o  out  1  response valid; data_rdata_o  out  XLEN  load data.
REQ-006 The shared memory port SHALL be: mem_req_o  out  1; mem_gnt_i  in  1; mem_we_o  out  1; mem_be_o  out  4; mem_addr_o  out  XLEN; mem_wdata_o  out  XLEN; mem_rvalid_i  in  1; mem_rdata_i  in  XLEN.

Function
REQ-007 The block SHALL implement an FSM with two states: IDLE (no transaction outstanding) and BUSY (one transaction granted, response pending).
REQ-008 The block SHALL allow at most one outstanding memory transaction.
REQ-009 The block SHALL consider the memory port free ("free") when the state is IDLE, or when the state is BUSY and mem_rvalid_i = 1 in the same cycle (back-to-back issue).
REQ-010 When free and at least one request is asserted, the block SHALL drive mem_req_o = 1 with the selected requester's address/we/be/wdata; the instruction requester SHALL drive mem_we_o = 0, mem_be_o = 4'b1111, mem_wdata_o = 0.
REQ-011 When not free, or when no request is asserted, the block SHALL drive mem_req_o = 0 and all other memory outputs to 0.
REQ-012 Selection SHALL be: only one requester active -> that requester; both active -> data, unless starve_cnt = STARVE_LIMIT, then instruction.
REQ-013 The block SHALL drive mem_gnt_i combinationally to the selected requester's gnt output only; the other gnt SHALL be 0.
REQ-014 On the cycle mem_req_o & mem_gnt_i is true, the block SHALL register the owner (INSTR/DATA) and enter BUSY; without a grant, the state SHALL NOT change.
REQ-015 In BUSY, the block SHALL forward mem_rvalid_i to the registered owner's rvalid output only (zero latency); the other rvalid SHALL be 0.
REQ-016 Both rdata outputs SHALL carry mem_rdata_i unconditionally.
REQ-017 On mem_rvalid_i in BUSY without a new grant, the next state SHALL be IDLE; with a new grant, the state SHALL remain BUSY with the new owner.
REQ-018 Write transactions SHALL also complete on mem_rvalid_i (acknowledge); data_rvalid_o SHALL pulse for writes as well.
REQ-019 The block SHALL ignore mem_rvalid_i in IDLE (spurious): no rvalid output, no state change.
REQ-020 starve_cnt SHALL be a 4-bit counter that increments (saturating at STARVE_LIMIT) on each data grant while instr_req_i = 1, and clears on an instruction grant or in any cycle with instr_req_i = 0.
REQ-021 A requester deasserting req before its grant SHALL abandon the request with no side effects (fetch kill case).

Reset
REQ-022 On arstn_i = 0, asynchronously: state = IDLE, owner = INSTR, starve_cnt = 0; with no requests, all outputs SHALL be 0.
REQ-023 Reset during BUSY SHALL discard the pending transaction; a late mem_rvalid_i after reset release SHALL be ignored per REQ-019.
REQ-024 After reset release, the first request SHALL be presentable to memory in the same cycle it is asserted.

Verification
REQ-025 Single fetch: instr_req_i = 1, addr 0x80; gnt in cycle 0, rvalid in cycle 2 with rdata 0x00000013 -> instr_gnt_o = 1 in cycle 0, instr_rvalid_o = 1 in cycle 2, data_* = 0 throughout.
REQ-026 Conflict: both request continuously, gnt/rvalid always 1, STARVE_LIMIT = 4 -> grant pattern D,D,D,D,I repeats; mem_addr_o alternates accordingly.
REQ-027 Back-to-back: BUSY with DATA owner; mem_rvalid_i = 1 while instr_req_i = 1 and mem_gnt_i = 1 -> data_rvalid_o = 1 and instr_gnt_o = 1 in the same cycle; owner becomes INSTR.
REQ-028 Store: data_we_i = 1, be = 4'b0011, wdata = 0xDEADBEEF -> mem_we_o = 1, mem_be_o = 4'b0011, mem_wdata_o = 0xDEADBEEF; data_rvalid_o pulses on ack.
REQ-029 Abort and reset: instr_req_i drops before gnt -> no transaction; arstn_i asserted while BUSY followed by mem_rvalid_i = 1 -> no rvalid output, state IDLE.

Source files
------------

// File: rtl/miriscv_pkg.sv
// Shared constants for the miriscv core.
package miriscv_pkg;
    parameter int XLEN = 32;
endpackage

// File: rtl/miriscv_mem_arbiter_if.sv
// Bundle of requester and shared-memory signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface miriscv_mem_arbiter_if;
    import miriscv_pkg::*;

    logic            instr_req_i;
    logic [XLEN-1:0] instr_addr_i;
    logic            instr_gnt_o;
    logic            instr_rvalid_o;
    logic [XLEN-1:0] instr_rdata_o;

    logic            data_req_i;
    logic            data_we_i;
    logic [3:0]      data_be_i;
    logic [XLEN-1:0] data_addr_i;
    logic [XLEN-1:0] data_wdata_i;
    logic            data_gnt_o;
    logic            data_rvalid_o;
    logic [XLEN-1:0] data_rdata_o;

    logic            mem_req_o;
    logic            mem_gnt_i;
    logic            mem_we_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one memory port with a single
// outstanding transaction. Data wins conflicts until fetch has waited STARVE_LIMIT grants.
module miriscv_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    miriscv_mem_arbiter_if.slave bus,
    output logic                 dbg_busy_o,
    output logic                 dbg_owner_data_o,
    output logic [3:0]           dbg_starve_cnt_o
);
    // Handshake: a request is presented with mem_req_o and accepted in the cycle
    // mem_gnt_i is high; its response (read data or write ack) arrives as one
    // mem_rvalid_i pulse, which may coincide with the grant of the next request.

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
    typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    logic free;
    logic sel_instr;
    logic issue;
    logic grant;
    logic resp;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INSTR;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;

        bus.mem_req_o      = 1'b0;
        bus.mem_we_o       = 1'b0;
        bus.mem_be_o       = 4'b0000;
        bus.mem_addr_o     = '0;
        bus.mem_wdata_o    = '0;
        bus.instr_gnt_o    = 1'b0;
        bus.data_gnt_o     = 1'b0;
        bus.instr_rvalid_o = 1'b0;
        bus.data_rvalid_o  = 1'b0;
        bus.instr_rdata_o  = bus.mem_rdata_i;
        bus.data_rdata_o   = bus.mem_rdata_i;

        // A response in BUSY frees the port in the same cycle for back-to-back issue.
        resp      = (state_q == BUSY) && bus.mem_rvalid_i;
        free      = (state_q == IDLE) || resp;
        sel_instr = bus.instr_req_i && (!bus.data_req_i || (starve_cnt_q == LIMIT));
        issue     = free && (bus.instr_req_i || bus.data_req_i);
        grant     = issue && bus.mem_gnt_i;

        if (issue) begin
            bus.mem_req_o = 1'b1;
            if (sel_instr) begin
                bus.mem_be_o   = 4'b1111;
                bus.mem_addr_o = bus.instr_addr_i;
            end else begin
                bus.mem_we_o    = bus.data_we_i;
                bus.mem_be_o    = bus.data_be_i;
                bus.mem_addr_o  = bus.data_addr_i;
                bus.mem_wdata_o = bus.data_wdata_i;
            end
        end

        bus.instr_gnt_o = grant && sel_instr;
        bus.data_gnt_o  = grant && !sel_instr;

        if (resp) begin
            bus.instr_rvalid_o = (owner_q == OWN_INSTR);
            bus.data_rvalid_o  = (owner_q == OWN_DATA);
            state_d            = IDLE;
        end

        if (grant) begin
            state_d = BUSY;
            owner_d = sel_instr ? OWN_INSTR : OWN_DATA;
        end

        // Only data grants that overtake a waiting fetch count toward starvation.
        if (!bus.instr_req_i || (grant && sel_instr)) begin
            starve_cnt_d = 4'd0;
        end else if (grant && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    assign dbg_busy_o       = (state_q == BUSY);
    assign dbg_owner_data_o = (owner_q == OWN_DATA);
    assign dbg_starve_cnt_o = starve_cnt_q;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Randomized and directed bench for miriscv_mem_arbiter against a transaction-level model.
module tb_miriscv_mem_arbiter;
  localparam int LIMIT = 4;

  // clock / reset
  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  miriscv_mem_arbiter_if bus_if();
  logic       dbg_busy;
  logic       dbg_owner_data;
  logic [3:0] dbg_starve;

  miriscv_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i            (clk),
    .arstn_i          (arstn),
    .bus              (bus_if),
    .dbg_busy_o       (dbg_busy),
    .dbg_owner_data_o (dbg_owner_data),
    .dbg_starve_cnt_o (dbg_starve)
  );

  // scoreboard: owners of outstanding transactions (0 = instr, 1 = data)
  logic [0:0] exp_q[$];
  int         starve;
  int         last_gnt;   // 0 none, 1 instr, 2 data
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus_if.instr_req_i  = 1'b0;
    bus_if.instr_addr_i = '0;
    bus_if.data_req_i   = 1'b0;
    bus_if.data_we_i    = 1'b0;
    bus_if.data_be_i    = '0;
    bus_if.data_addr_i  = '0;
    bus_if.data_wdata_i = '0;
    bus_if.mem_gnt_i    = 1'b0;
    bus_if.mem_rvalid_i = 1'b0;
    bus_if.mem_rdata_i  = '0;
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, advance the model.
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dwe, input logic [3:0] dbe,
                      input logic [31:0] da, input logic [31:0] dwd,
                      input logic mg, input logic mr, input logic [31:0] mrd);
    logic        pending, free, want_i, want_d, issue, grant;
    logic [0:0]  head;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_be;
    @(negedge clk);
    bus_if.instr_req_i  = ir;
    bus_if.instr_addr_i = ia;
    bus_if.data_req_i   = dr;
    bus_if.data_we_i    = dwe;
    bus_if.data_be_i    = dbe;
    bus_if.data_addr_i  = da;
    bus_if.data_wdata_i = dwd;
    bus_if.mem_gnt_i    = mg;
    bus_if.mem_rvalid_i = mr;
    bus_if.mem_rdata_i  = mrd;
    #1;
    pending = (exp_q.size() != 0);
    head    = pending ? exp_q[0] : 1'b0;
    free    = !pending || mr;
    want_i  = ir && (!dr || starve >= LIMIT);
    want_d  = dr && !want_i;
    issue   = free && (ir || dr);
    grant   = issue && mg;
    e_addr  = !issue ? 32'h0 : (want_i ? ia : da);
    e_wdata = (issue && want_d) ? dwd : 32'h0;
    e_we    = issue && want_d && dwe;
    e_be    = !issue ? 4'h0 : (want_i ? 4'hF : dbe);

    check("mem_req",      {31'b0, bus_if.mem_req_o}, {31'b0, issue});
    check("mem_addr",     bus_if.mem_addr_o, e_addr);
    check("mem_we",       {31'b0, bus_if.mem_we_o}, {31'b0, e_we});
    check("mem_be",       {28'b0, bus_if.mem_be_o}, {28'b0, e_be});
    check("mem_wdata",    bus_if.mem_wdata_o, e_wdata);
    check("instr_gnt",    {31'b0, bus_if.instr_gnt_o}, {31'b0, grant && want_i});
    check("data_gnt",     {31'b0, bus_if.data_gnt_o}, {31'b0, grant && want_d});
    check("instr_rvalid", {31'b0, bus_if.instr_rvalid_o}, {31'b0, pending && mr && head == 1'b0});
    check("data_rvalid",  {31'b0, bus_if.data_rvalid_o}, {31'b0, pending && mr && head == 1'b1});
    check("instr_rdata",  bus_if.instr_rdata_o, mrd);
    check("data_rdata",   bus_if.data_rdata_o, mrd);

    last_gnt = !grant ? 0 : (want_i ? 1 : 2);
    if (pending && mr) void'(exp_q.pop_front());
    if (grant) exp_q.push_back(want_d);
    if (!ir || (grant && want_i)) starve = 0;
    else if (grant && want_d && starve < LIMIT) starve++;
  endtask

  // Asynchronous reset asserted mid-cycle; checks take effect before the next clock edge.
  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    #2;
    arstn = 1'b0;
    #1;
    check("rst_busy",    {31'b0, dbg_busy}, 32'h0);
    check("rst_owner",   {31'b0, dbg_owner_data}, 32'h0);
    check("rst_starve",  {28'b0, dbg_starve}, 32'h0);
    check("rst_mem_req", {31'b0, bus_if.mem_req_o}, 32'h0);
    check("rst_gnts",    {30'b0, bus_if.instr_gnt_o, bus_if.data_gnt_o}, 32'h0);
    check("rst_rvalids", {30'b0, bus_if.instr_rvalid_o, bus_if.data_rvalid_o}, 32'h0);
    exp_q.delete();
    starve = 0;
    @(negedge clk);
    arstn = 1'b1;
  endtask

  initial begin
    logic [9:0] pat;
    logic       ir, dr, dwe, mg, mr;
    arstn = 1'b0;
    drive_idle();
    starve   = 0;
    last_gnt = 0;
    do_reset();

    // single fetch: grant at cycle 0, response at cycle 2
    step(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00000013);

    // store with partial byte enables, acknowledged two cycles later
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h1000, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);

    // continuous conflict: D,D,D,D,I repeating
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 4'hF, 32'h400 + 32'(i), 32'h0, 1'b1, 1'b1, 32'(i));
      pat[i] = (last_gnt == 1);
    end
    check("conflict_pattern", {22'b0, pat}, {22'b0, 10'b1000010000});
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);

    // back-to-back: data response and fetch grant in the same cycle
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h84, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h55AA55AA);
    @(posedge clk); #1;
    check("b2b_busy",  {31'b0, dbg_busy}, 32'h1);
    check("b2b_owner", {31'b0, dbg_owner_data}, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h13);

    // fetch kill: request withdrawn before grant, then a spurious response in IDLE
    step(1'b1, 32'h88, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    @(posedge clk); #1;
    check("abort_idle", {31'b0, dbg_busy}, 32'h0);

    // reset while BUSY, then a late response must be ignored
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 1'b1, 1'b0, 32'h0);
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h77);
    @(posedge clk); #1;
    check("late_rvalid_idle", {31'b0, dbg_busy}, 32'h0);

    // randomized traffic with random memory latency and spurious responses
    for (int i = 0; i < 600; i++) begin
      ir  = ($urandom_range(0, 3) != 0);
      dr  = ($urandom_range(0, 3) != 0);
      dwe = $urandom_range(0, 1) == 1;
      mg  = ($urandom_range(0, 3) != 0);
      mr  = $urandom_range(0, 1) == 1;
      step(ir, $urandom, dr, dwe, 4'($urandom_range(0, 15)), $urandom, $urandom, mg, mr, $urandom);
      if (i == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
